// File: rtl/axi_wrr_arb_if.sv
// axi_wrr_arb shared types and AXI4 bus interface.
//
// axi_wrr_arb_pkg:
//   SoftRegReq  - softreg request  {valid, isWrite, addr[31:0], data[63:0]}
//   SoftRegResp - softreg response {valid, data[63:0]}
//   axi_ax_t    - AR/AW payload    {id[15:0], addr[63:0], len, size, burst}
//
// axi_bus_t: AXI4 bus with 512-bit data, 64-bit address and 16-bit ID.
//   Modport master drives AR/AW/W and the R/B readies.
//   Modport slave drives the AR/AW/W readies and R/B.
package axi_wrr_arb_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;
endpackage

interface axi_bus_t;
    import axi_wrr_arb_pkg::*;
    axi_ax_t      ar;
    logic         arvalid, arready;
    axi_ax_t      aw;
    logic         awvalid, awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [15:0]  rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    modport master (
        output ar, arvalid, aw, awvalid, wdata, wstrb, wlast, wvalid, rready, bready,
        input  arready, awready, wready, rid, rdata, rresp, rlast, rvalid, bid, bresp, bvalid
    );
    modport slave (
        input  ar, arvalid, aw, awvalid, wdata, wstrb, wlast, wvalid, rready, bready,
        output arready, awready, wready, rid, rdata, rresp, rlast, rvalid, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_wrr_arb.sv
// axi_wrr_arb: N-port to 1-port AXI4 merge with weighted round-robin on AR
// and AW, a per-port outstanding-burst limit per direction, W ordering
// through a write-order FIFO, and ID-based R/B routing.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   sr_req    - softreg request; window is SR_ADDR .. SR_ADDR+'h1F
//   sr_resp   - softreg read response, valid one cycle after the request
//   axi_s[]   - upstream slave ports (ID[15:16-IDX_W] must be zero)
//   axi_m     - merged master port, ID = {port index, upstream ID low bits}
//
// Softreg map (offset from SR_ADDR):
//   i           weight[i] (write, 0 stored as 1); read {wr_outs, rd_outs, weight}
//   'h10+2i     grant counter (AR+AW), AXI_WRR_ARB_PERF_EN only
//   'h11+2i     stall counter,        AXI_WRR_ARB_PERF_EN only
// Optional feature macro: AXI_WRR_ARB_PERF_EN (per-port perf counters).
//
// Handshakes: every channel follows AXI valid/ready; a transfer happens on
// the rising edge where both are high, and a valid source holds its payload
// stable until that edge.
module axi_wrr_arb
    import axi_wrr_arb_pkg::*;
#(
    parameter int          N_PORTS  = 4,
    parameter int          IDX_W    = $clog2(N_PORTS),
    parameter int          MAX_OUTS = 16,
    parameter int          WQ_DEPTH = 8,
    parameter logic [31:0] SR_ADDR  = 32'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  SoftRegReq  sr_req,
    output SoftRegResp sr_resp,
    axi_bus_t.slave    axi_s [N_PORTS],
    axi_bus_t.master   axi_m
);
    localparam int OW = $clog2(MAX_OUTS + 1);
    localparam int QW = $clog2(WQ_DEPTH);
    localparam int LW = 16 - IDX_W;

    axi_ax_t            s_ar [N_PORTS];
    axi_ax_t            s_aw [N_PORTS];
    logic [511:0]       s_wdata [N_PORTS];
    logic [63:0]        s_wstrb [N_PORTS];
    logic [N_PORTS-1:0] s_arvalid, s_awvalid, s_wvalid, s_wlast, s_rready, s_bready;

    logic [7:0]         weight  [N_PORTS];
    logic [OW-1:0]      rd_outs [N_PORTS];
    logic [OW-1:0]      wr_outs [N_PORTS];
    logic [IDX_W-1:0]   rd_ptr, wr_ptr;
    logic [7:0]         rd_cred, wr_cred;

    axi_ax_t            ar_q, aw_q, ar_fwd, aw_fwd;
    logic               ar_vld_q, aw_vld_q;

    logic [IDX_W-1:0]   wq_mem [WQ_DEPTH];
    logic [QW:0]        wq_wp, wq_rp;
    logic               wq_empty, wq_full, w_pop;
    logic [IDX_W-1:0]   wq_head;

    logic [N_PORTS-1:0] ar_elig, aw_elig, ar_gnt, aw_gnt, rd_dec, wr_dec;
    logic               ar_found, aw_found, ar_hs, aw_hs, r_done, b_done;
    logic [IDX_W-1:0]   ar_idx, aw_idx, r_port, b_port;

    logic [31:0]        sr_rel;
    logic               sr_win, sr_wr, sr_rd;
    logic [63:0]        sr_rdata;
    logic               unused_sr_bits;

    // First eligible port at or after ptr (wrapping); MSB of result = found.
    function automatic logic [IDX_W:0] pick(input logic [N_PORTS-1:0] elig,
                                            input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] r;
        int             j;
        r = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_PORTS;
            if (elig[j]) r = {1'b1, IDX_W'(j)};
        end
        return r;
    endfunction

    // Pointer/credit update after granting port g. A grant to anyone other
    // than the holder (holder went idle) makes g the new holder.
    function automatic logic [IDX_W+7:0] advance(input logic [IDX_W-1:0] g,
                                                 input logic [IDX_W-1:0] ptr,
                                                 input logic [7:0] cred,
                                                 input logic [7:0] w);
        logic [8:0]       cnt;
        logic [IDX_W-1:0] nxt;
        cnt = (g == ptr) ? {1'b0, cred} + 9'd1 : 9'd1;
        nxt = (g == IDX_W'(N_PORTS - 1)) ? '0 : g + 1'b1;
        if (cnt >= {1'b0, w}) return {nxt, 8'd0};
        return {g, cnt[7:0]};
    endfunction

    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
        assign s_ar[g]      = axi_s[g].ar;
        assign s_arvalid[g] = axi_s[g].arvalid;
        assign s_aw[g]      = axi_s[g].aw;
        assign s_awvalid[g] = axi_s[g].awvalid;
        assign s_wdata[g]   = axi_s[g].wdata;
        assign s_wstrb[g]   = axi_s[g].wstrb;
        assign s_wlast[g]   = axi_s[g].wlast;
        assign s_wvalid[g]  = axi_s[g].wvalid;
        assign s_rready[g]  = axi_s[g].rready;
        assign s_bready[g]  = axi_s[g].bready;

        assign axi_s[g].arready = ar_gnt[g];
        assign axi_s[g].awready = aw_gnt[g];
        assign axi_s[g].wready  = !wq_empty && (wq_head == IDX_W'(g)) && axi_m.wready;
        assign axi_s[g].rvalid  = !rst && axi_m.rvalid && (r_port == IDX_W'(g));
        assign axi_s[g].rid     = {{IDX_W{1'b0}}, axi_m.rid[LW-1:0]};
        assign axi_s[g].rdata   = axi_m.rdata;
        assign axi_s[g].rresp   = axi_m.rresp;
        assign axi_s[g].rlast   = axi_m.rlast;
        assign axi_s[g].bvalid  = !rst && axi_m.bvalid && (b_port == IDX_W'(g));
        assign axi_s[g].bid     = {{IDX_W{1'b0}}, axi_m.bid[LW-1:0]};
        assign axi_s[g].bresp   = axi_m.bresp;
    end

    assign wq_empty = (wq_wp == wq_rp);
    assign wq_full  = (wq_wp[QW] != wq_rp[QW]) && (wq_wp[QW-1:0] == wq_rp[QW-1:0]);
    assign wq_head  = wq_mem[wq_rp[QW-1:0]];
    assign w_pop    = !wq_empty && s_wvalid[wq_head] && axi_m.wready && s_wlast[wq_head];

    assign r_port = axi_m.rid[15 -: IDX_W];
    assign b_port = axi_m.bid[15 -: IDX_W];
    assign r_done = axi_m.rvalid && axi_m.rready && axi_m.rlast;
    assign b_done = axi_m.bvalid && axi_m.bready;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            ar_elig[i] = s_arvalid[i] && (rd_outs[i] < OW'(MAX_OUTS));
            aw_elig[i] = s_awvalid[i] && (wr_outs[i] < OW'(MAX_OUTS));
        end
        {ar_found, ar_idx} = pick(ar_elig, rd_ptr);
        {aw_found, aw_idx} = pick(aw_elig, wr_ptr);
        // Slices accept when empty or draining this cycle; the write-order
        // FIFO accepts a push when full only alongside a pop.
        ar_hs = !rst && ar_found && (!ar_vld_q || axi_m.arready);
        aw_hs = !rst && aw_found && (!aw_vld_q || axi_m.awready) && (!wq_full || w_pop);
        for (int i = 0; i < N_PORTS; i++) begin
            ar_gnt[i] = ar_hs && (ar_idx == IDX_W'(i));
            aw_gnt[i] = aw_hs && (aw_idx == IDX_W'(i));
            rd_dec[i] = r_done && (r_port == IDX_W'(i)) && (rd_outs[i] != '0);
            wr_dec[i] = b_done && (b_port == IDX_W'(i)) && (wr_outs[i] != '0);
        end
        ar_fwd    = s_ar[ar_idx];
        ar_fwd.id = {ar_idx, s_ar[ar_idx].id[LW-1:0]};
        aw_fwd    = s_aw[aw_idx];
        aw_fwd.id = {aw_idx, s_aw[aw_idx].id[LW-1:0]};
    end

    assign axi_m.ar      = ar_q;
    assign axi_m.arvalid = ar_vld_q;
    assign axi_m.aw      = aw_q;
    assign axi_m.awvalid = aw_vld_q;
    assign axi_m.wdata   = s_wdata[wq_head];
    assign axi_m.wstrb   = s_wstrb[wq_head];
    assign axi_m.wlast   = s_wlast[wq_head];
    assign axi_m.wvalid  = !wq_empty && s_wvalid[wq_head];
    assign axi_m.rready  = s_rready[r_port];
    assign axi_m.bready  = s_bready[b_port];

    assign sr_rel = sr_req.addr - SR_ADDR;
    assign sr_win = sr_req.valid && (sr_rel < 32'd32);
    assign sr_wr  = sr_win && sr_req.isWrite;
    assign sr_rd  = sr_win && !sr_req.isWrite;
    assign unused_sr_bits = ^sr_req.data[63:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_vld_q <= 1'b0;
            aw_vld_q <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rd_cred  <= '0;
            wr_cred  <= '0;
            wq_wp    <= '0;
            wq_rp    <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                weight[i]  <= 8'd1;
                rd_outs[i] <= '0;
                wr_outs[i] <= '0;
            end
        end else begin
            if (ar_hs) begin
                ar_q              <= ar_fwd;
                ar_vld_q          <= 1'b1;
                {rd_ptr, rd_cred} <= advance(ar_idx, rd_ptr, rd_cred, weight[ar_idx]);
            end else if (axi_m.arready) begin
                ar_vld_q <= 1'b0;
            end
            if (aw_hs) begin
                aw_q                     <= aw_fwd;
                aw_vld_q                 <= 1'b1;
                {wr_ptr, wr_cred}        <= advance(aw_idx, wr_ptr, wr_cred, weight[aw_idx]);
                wq_mem[wq_wp[QW-1:0]]    <= aw_idx;
                wq_wp                    <= wq_wp + 1'b1;
            end else if (axi_m.awready) begin
                aw_vld_q <= 1'b0;
            end
            if (w_pop) wq_rp <= wq_rp + 1'b1;
            for (int i = 0; i < N_PORTS; i++) begin
                if (ar_gnt[i] && !rd_dec[i])      rd_outs[i] <= rd_outs[i] + 1'b1;
                else if (!ar_gnt[i] && rd_dec[i]) rd_outs[i] <= rd_outs[i] - 1'b1;
                if (aw_gnt[i] && !wr_dec[i])      wr_outs[i] <= wr_outs[i] + 1'b1;
                else if (!aw_gnt[i] && wr_dec[i]) wr_outs[i] <= wr_outs[i] - 1'b1;
                if (sr_wr && sr_rel == 32'(i))
                    weight[i] <= (sr_req.data[7:0] == 8'd0) ? 8'd1 : sr_req.data[7:0];
            end
        end
    end

`ifdef AXI_WRR_ARB_PERF_EN
    logic [31:0] gnt_cnt   [N_PORTS];
    logic [31:0] stall_cnt [N_PORTS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (rst || (sr_wr && (sr_rel == 32'('h10 + 2 * i) || sr_rel == 32'('h11 + 2 * i)))) begin
                gnt_cnt[i]   <= '0;
                stall_cnt[i] <= '0;
            end else begin
                // Saturating add of 0..2 grants (AR and AW may both win).
                if ({1'b0, gnt_cnt[i]} + 33'(ar_gnt[i]) + 33'(aw_gnt[i]) > 33'hFFFF_FFFF)
                    gnt_cnt[i] <= '1;
                else
                    gnt_cnt[i] <= gnt_cnt[i] + 32'(ar_gnt[i]) + 32'(aw_gnt[i]);
                if (((s_arvalid[i] && !ar_gnt[i]) || (s_awvalid[i] && !aw_gnt[i]))
                    && stall_cnt[i] != '1)
                    stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sr_rdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (sr_rel == 32'(i)) sr_rdata = 64'({wr_outs[i], rd_outs[i], weight[i]});
`ifdef AXI_WRR_ARB_PERF_EN
            if (sr_rel == 32'('h10 + 2 * i)) sr_rdata = 64'(gnt_cnt[i]);
            if (sr_rel == 32'('h11 + 2 * i)) sr_rdata = 64'(stall_cnt[i]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_resp <= '0;
        end else begin
            sr_resp.valid <= sr_rd;
            sr_resp.data  <= sr_rdata;
        end
    end
endmodule

// File: tb/tb_axi_wrr_arb.sv
module tb_axi_wrr_arb;
    import axi_wrr_arb_pkg::*;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    SoftRegReq  sr_req;
    SoftRegResp sr_resp;

    always #5 clk = ~clk;

    axi_bus_t s_if [N] ();
    axi_bus_t m_if ();

    axi_wrr_arb #(.N_PORTS(N)) dut (
        .clk(clk), .rst(rst), .sr_req(sr_req), .sr_resp(sr_resp),
        .axi_s(s_if), .axi_m(m_if)
    );

    axi_ax_t      tb_ar [N];
    axi_ax_t      tb_aw [N];
    logic [511:0] tb_wdata [N];
    logic [N-1:0] tb_arvalid, tb_awvalid, tb_wvalid, tb_wlast, tb_rready, tb_bready;
    logic [N-1:0] o_arready, o_awready, o_wready, o_rvalid, o_bvalid;
    logic [15:0]  o_rid [N];
    logic [15:0]  o_bid [N];

    for (genvar g = 0; g < N; g++) begin : g_s
        assign s_if[g].ar      = tb_ar[g];
        assign s_if[g].arvalid = tb_arvalid[g];
        assign s_if[g].aw      = tb_aw[g];
        assign s_if[g].awvalid = tb_awvalid[g];
        assign s_if[g].wdata   = tb_wdata[g];
        assign s_if[g].wstrb   = '1;
        assign s_if[g].wlast   = tb_wlast[g];
        assign s_if[g].wvalid  = tb_wvalid[g];
        assign s_if[g].rready  = tb_rready[g];
        assign s_if[g].bready  = tb_bready[g];
        assign o_arready[g]    = s_if[g].arready;
        assign o_awready[g]    = s_if[g].awready;
        assign o_wready[g]     = s_if[g].wready;
        assign o_rvalid[g]     = s_if[g].rvalid;
        assign o_bvalid[g]     = s_if[g].bvalid;
        assign o_rid[g]        = s_if[g].rid;
        assign o_bid[g]        = s_if[g].bid;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic axi_ax_t mk_ax(input logic [15:0] id, input logic [63:0] addr);
        axi_ax_t a;
        a = '0;
        a.id = id;
        a.addr = addr;
        a.len = 8'd0;
        a.size = 3'd6;
        a.burst = 2'd1;
        return a;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        int r;
        r = -1;
        if ($countones(v) == 1)
            for (int k = 0; k < N; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tb_arvalid = '0; tb_awvalid = '0; tb_wvalid = '0; tb_wlast = '0;
        tb_rready = '0; tb_bready = '0;
        for (int i = 0; i < N; i++) begin
            tb_ar[i] = '0; tb_aw[i] = '0; tb_wdata[i] = '0;
        end
        m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
        m_if.rvalid = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0;
        sr_req = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        sr_req.valid = 1'b1; sr_req.isWrite = 1'b1; sr_req.addr = a; sr_req.data = d;
        tick();
        sr_req.valid = 1'b0;
    endtask

    task automatic sr_read_check(input string tag, input logic [31:0] a,
                                 input logic exp_v, input logic [63:0] exp_d);
        sr_req.valid = 1'b1; sr_req.isWrite = 1'b0; sr_req.addr = a; sr_req.data = '0;
        tick();
        sr_req.valid = 1'b0;
        #1;
        check({tag, ".valid"}, 64'(sr_resp.valid), 64'(exp_v));
        if (exp_v) check({tag, ".data"}, sr_resp.data, exp_d);
    endtask

    initial begin
        int cnt;
        logic [63:0] e;

        // Reset: readies gated even with valid requests pending.
        do_reset();
        rst = 1'b1;
        tb_arvalid = '1;
        tb_awvalid = '1;
        tick();
        check("rst.arready", 64'(o_arready), 64'h0);
        check("rst.awready", 64'(o_awready), 64'h0);
        check("rst.m_valid", 64'({m_if.arvalid, m_if.awvalid, m_if.wvalid}), 64'h0);
        check("rst.sr_valid", 64'(sr_resp.valid), 64'h0);
        do_reset();

        // Test 1: single AR from port 2, R routed back to port 2 only.
        tb_ar[2] = mk_ax(16'h0005, 64'h1000);
        tb_arvalid[2] = 1'b1;
        #1;
        check("t1.arready", 64'(o_arready), 64'h4);
        check("t1.m_arvalid_pre", 64'(m_if.arvalid), 64'h0);
        tick();
        tb_arvalid[2] = 1'b0;
        #1;
        check("t1.m_arvalid", 64'(m_if.arvalid), 64'h1);
        check("t1.m_arid", 64'(m_if.ar.id), 64'h8005);
        check("t1.m_araddr", m_if.ar.addr, 64'h1000);
        tick();
        check("t1.m_arvalid_drain", 64'(m_if.arvalid), 64'h0);
        sr_read_check("t1.outs_pre", 32'h22, 1'b1, 64'h101);
        m_if.rvalid = 1'b1; m_if.rid = 16'h8005; m_if.rlast = 1'b1;
        tb_rready = 4'b1011;
        #1;
        check("t1.rvalid_route", 64'(o_rvalid), 64'h4);
        check("t1.rid", 64'(o_rid[2]), 64'h0005);
        check("t1.m_rready_off", 64'(m_if.rready), 64'h0);
        tb_rready = 4'b0100;
        #1;
        check("t1.m_rready_on", 64'(m_if.rready), 64'h1);
        tick();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        sr_read_check("t1.outs_post", 32'h22, 1'b1, 64'h001);

        // Test 2: weighted round-robin with weights {1,2,1,4}.
        do_reset();
        sr_write(32'h20, 64'd1);
        sr_write(32'h21, 64'd2);
        sr_write(32'h22, 64'd1);
        sr_write(32'h23, 64'd4);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
            exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
        end
        for (int i = 0; i < N; i++) tb_ar[i] = mk_ax(16'(i), 64'(i));
        tb_arvalid = '1;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k > 0) check("t2.fwd_port", 64'(m_if.ar.id[15:14]), e);
            e = exp_q.pop_front();
            check("t2.grant", 64'(idx_of(o_arready)), e);
            tick();
        end
        tb_arvalid = '0;

        // Test 3: outstanding read limit on port 0.
        do_reset();
        tb_ar[0] = mk_ax(16'h0001, 64'h40);
        tb_arvalid[0] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (o_arready[0]) cnt++;
            tick();
        end
        check("t3.forwarded", 64'(cnt), 64'd16);
        check("t3.arready_blocked", 64'(o_arready[0]), 64'h0);
        sr_read_check("t3.rd_outs", 32'h20, 1'b1, 64'h1001);
        m_if.rvalid = 1'b1; m_if.rid = 16'h0001; m_if.rlast = 1'b1;
        tb_rready[0] = 1'b1;
        #1;
        check("t3.rvalid", 64'(o_rvalid), 64'h1);
        tick();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        #1;
        check("t3.arready_17th", 64'(o_arready[0]), 64'h1);
        tick();
        check("t3.m_arvalid_17th", 64'(m_if.arvalid), 64'h1);
        check("t3.arready_reblocked", 64'(o_arready[0]), 64'h0);
        tb_arvalid[0] = 1'b0;

        // Test 4: W ordering follows AW order; B routed by ID.
        do_reset();
        tb_aw[1] = mk_ax(16'h0007, 64'h100);
        tb_awvalid[1] = 1'b1;
        #1;
        check("t4.awready1", 64'(o_awready), 64'h2);
        tick();
        tb_awvalid[1] = 1'b0;
        tb_aw[3] = mk_ax(16'h0009, 64'h300);
        tb_awvalid[3] = 1'b1;
        #1;
        check("t4.m_awid1", 64'(m_if.aw.id), 64'h4007);
        tick();
        tb_awvalid[3] = 1'b0;
        #1;
        check("t4.m_awid3", 64'(m_if.aw.id), 64'hC009);
        exp_q.push_back(64'h11); exp_q.push_back(64'h12); exp_q.push_back(64'h33);
        tb_wvalid[3] = 1'b1; tb_wlast[3] = 1'b1; tb_wdata[3] = 512'h33;
        #1;
        check("t4.p3_blocked", 64'(o_wready[3]), 64'h0);
        check("t4.m_wvalid_blocked", 64'(m_if.wvalid), 64'h0);
        tick();
        tb_wvalid[1] = 1'b1; tb_wlast[1] = 1'b0; tb_wdata[1] = 512'h11;
        #1;
        check("t4.wready_p1", 64'(o_wready), 64'h2);
        check("t4.wdata0", m_if.wdata[63:0], exp_q.pop_front());
        tick();
        tb_wlast[1] = 1'b1; tb_wdata[1] = 512'h12;
        #1;
        check("t4.wdata1", m_if.wdata[63:0], exp_q.pop_front());
        check("t4.wlast1", 64'(m_if.wlast), 64'h1);
        tick();
        tb_wvalid[1] = 1'b0; tb_wlast[1] = 1'b0;
        #1;
        check("t4.wready_p3", 64'(o_wready), 64'h8);
        check("t4.wdata2", m_if.wdata[63:0], exp_q.pop_front());
        tick();
        tb_wvalid[3] = 1'b0; tb_wlast[3] = 1'b0;
        #1;
        check("t4.w_empty", 64'(m_if.wvalid), 64'h0);
        sr_read_check("t4.wr_outs_pre", 32'h21, 1'b1, 64'h2001);
        m_if.bvalid = 1'b1; m_if.bid = 16'h4007; tb_bready = '1;
        #1;
        check("t4.bvalid_route", 64'(o_bvalid), 64'h2);
        check("t4.bid", 64'(o_bid[1]), 64'h0007);
        tick();
        m_if.bvalid = 1'b0;
        sr_read_check("t4.wr_outs_post", 32'h21, 1'b1, 64'h0001);

        // Test 5: W FIFO full; push with simultaneous pop keeps it at 8.
        do_reset();
        tb_aw[0] = mk_ax(16'h0002, 64'h0);
        tb_awvalid[0] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o_awready[0]) cnt++;
            tick();
        end
        check("t5.granted", 64'(cnt), 64'd8);
        check("t5.ninth_blocked", 64'(o_awready[0]), 64'h0);
        tb_wvalid[0] = 1'b1; tb_wlast[0] = 1'b1; tb_wdata[0] = 512'h55;
        #1;
        check("t5.push_with_pop", 64'({o_awready[0], o_wready[0]}), 64'h3);
        tick();
        tb_awvalid[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t5.drain", 64'(o_wready[0]), 64'h1);
            tick();
        end
        check("t5.empty_after_8", 64'({o_wready[0], m_if.wvalid}), 64'h0);
        tb_wvalid[0] = 1'b0; tb_wlast[0] = 1'b0;

        // Test 6: softreg weights and unmapped addresses.
        do_reset();
        sr_write(32'h21, 64'd5);
        sr_read_check("t6.w5", 32'h21, 1'b1, 64'h005);
        sr_write(32'h21, 64'd0);
        sr_read_check("t6.w0_as_1", 32'h21, 1'b1, 64'h001);
        sr_read_check("t6.perf_off", 32'h30, 1'b1, 64'h0);
        sr_read_check("t6.hole", 32'h24, 1'b1, 64'h0);
        sr_read_check("t6.outside", 32'h40, 1'b0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
